channel_deinterleave_12: RTL



---
 rtl/channel_deinterleave_12_pkg.sv | 23 ++
 rtl/channel_deinterleave_12_if.sv | 37 +++
 rtl/channel_deinterleave_12_frame_pixel_counter.sv | 48 ++++
 rtl/channel_deinterleave_12.sv | 82 ++++++++
 4 files changed

// File: rtl/channel_deinterleave_12_pkg.sv
// Shared constants and helpers for the 12-channel deinterleaver and its
// frame/pixel position counter.
package channel_deinterleave_12_pkg;

    localparam int unsigned NUM_CH         = 12;
    localparam int unsigned CH_W           = 4;
    localparam int unsigned DEF_IMG_WIDTH  = 3;
    localparam int unsigned DEF_IMG_HEIGHT = 3;
    localparam int unsigned FRAME_PIX      = DEF_IMG_WIDTH * DEF_IMG_HEIGHT;

    typedef logic [CH_W-1:0] ch_cnt_t;

    // Ceiling log2, never below 1 so a one-pixel frame still gets a counter bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/channel_deinterleave_12_if.sv
// Serial channel-word input plus 12-wide pixel output bundle.
interface channel_deinterleave_12_if #(
    parameter int unsigned Datawidth = 32
);
    logic                 valid_in;
    logic                 sof;
    logic [Datawidth-1:0] In;
    logic [Datawidth-1:0] Out_0;
    logic [Datawidth-1:0] Out_1;
    logic [Datawidth-1:0] Out_2;
    logic [Datawidth-1:0] Out_3;
    logic [Datawidth-1:0] Out_4;
    logic [Datawidth-1:0] Out_5;
    logic [Datawidth-1:0] Out_6;
    logic [Datawidth-1:0] Out_7;
    logic [Datawidth-1:0] Out_8;
    logic [Datawidth-1:0] Out_9;
    logic [Datawidth-1:0] Out_10;
    logic [Datawidth-1:0] Out_11;
    logic                 valid_out;
    logic                 frame_done;
    logic                 sync_err;

    modport master (
        output valid_in, sof, In,
        input  Out_0, Out_1, Out_2, Out_3, Out_4, Out_5,
               Out_6, Out_7, Out_8, Out_9, Out_10, Out_11,
               valid_out, frame_done, sync_err
    );

    modport slave (
        input  valid_in, sof, In,
        output Out_0, Out_1, Out_2, Out_3, Out_4, Out_5,
               Out_6, Out_7, Out_8, Out_9, Out_10, Out_11,
               valid_out, frame_done, sync_err
    );
endinterface

// File: rtl/channel_deinterleave_12_frame_pixel_counter.sv
// Channel/pixel position tracker with sof restart and frame sync error pulse;
// shared between the deinterleaver and the matching serializer.
module frame_pixel_counter
    import channel_deinterleave_12_pkg::*;
#(
    parameter int unsigned FRAME_SIZE = FRAME_PIX,
    parameter int unsigned PIX_W      = clog2(FRAME_PIX)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic             sof,
    output ch_cnt_t          ch_cnt,
    output logic [PIX_W-1:0] pix_cnt,
    output logic             group_last,
    output logic             frame_last,
    output logic             sync_err
);

    // sof always wins over completion, even on the 12th word of a pixel.
    always_comb begin
        group_last = valid && !sof && (ch_cnt == CH_W'(NUM_CH - 1));
        frame_last = group_last && (pix_cnt == PIX_W'(FRAME_SIZE - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt   <= '0;
            pix_cnt  <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (valid) begin
                if (sof) begin
                    sync_err <= (ch_cnt != '0) || (pix_cnt != '0);
                    ch_cnt   <= CH_W'(1);
                    pix_cnt  <= '0;
                end else if (group_last) begin
                    ch_cnt  <= '0;
                    pix_cnt <= frame_last ? '0 : pix_cnt + PIX_W'(1);
                end else begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/channel_deinterleave_12.sv
// Collects 12 serial channel words per pixel into a shadow file and presents
// the completed pixel on 12 parallel output registers with a valid pulse.
module channel_deinterleave_12
    import channel_deinterleave_12_pkg::*;
#(
    parameter int unsigned IMG_Width  = DEF_IMG_WIDTH,
    parameter int unsigned IMG_Height = DEF_IMG_HEIGHT,
    parameter int unsigned Datawidth  = 32
) (
    input logic                      clk,
    input logic                      rst,
    channel_deinterleave_12_if.slave bus
);

    localparam int unsigned FRAME_SIZE = IMG_Width * IMG_Height;
    localparam int unsigned PIX_W      = clog2(FRAME_SIZE);

    ch_cnt_t              ch_cnt;
    logic [PIX_W-1:0]     pix_cnt;
    logic                 group_last;
    logic                 frame_last;
    logic [Datawidth-1:0] shadow [NUM_CH-1];
    logic [Datawidth-1:0] out_q  [NUM_CH];
    logic                 valid_q;
    logic                 done_q;

    frame_pixel_counter #(
        .FRAME_SIZE (FRAME_SIZE),
        .PIX_W      (PIX_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .valid      (bus.valid_in),
        .sof        (bus.sof),
        .ch_cnt     (ch_cnt),
        .pix_cnt    (pix_cnt),
        .group_last (group_last),
        .frame_last (frame_last),
        .sync_err   (bus.sync_err)
    );

    // Last word bypasses the shadow file straight into Out_11.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_CH - 1; k++) shadow[k] <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) out_q[k] <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (bus.valid_in) begin
                if (bus.sof) begin
                    shadow[0] <= bus.In;
                end else if (group_last) begin
                    for (int unsigned k = 0; k < NUM_CH - 1; k++) out_q[k] <= shadow[k];
                    out_q[NUM_CH-1] <= bus.In;
                    valid_q <= 1'b1;
                    done_q  <= frame_last;
                end else begin
                    shadow[ch_cnt] <= bus.In;
                end
            end
        end
    end

    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
    assign bus.Out_0      = out_q[0];
    assign bus.Out_1      = out_q[1];
    assign bus.Out_2      = out_q[2];
    assign bus.Out_3      = out_q[3];
    assign bus.Out_4      = out_q[4];
    assign bus.Out_5      = out_q[5];
    assign bus.Out_6      = out_q[6];
    assign bus.Out_7      = out_q[7];
    assign bus.Out_8      = out_q[8];
    assign bus.Out_9      = out_q[9];
    assign bus.Out_10     = out_q[10];
    assign bus.Out_11     = out_q[11];

endmodule
